// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// MULT/MULTU take WIDTH cycles of shift-add; DIV/DIVU take WIDTH cycles of
// restoring division. Both are followed by one sign-fixup cycle (FIX).
// MTHI/MTLO write HI/LO directly in IDLE and never raise busy.
//
// Handshake: start is sampled only on a rising edge where busy=0. A request
// sampled while busy=1 is dropped, not queued. done is a one-cycle pulse in the
// cycle after HI/LO were written by a mul/div (including divide-by-zero).
// flush returns the unit to IDLE on the next edge and wins over start and FIX.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   LAST   = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0] cnt;
  // Mul: acc_hi = running upper product, acc_lo = multiplier shifting out.
  // Div: acc_hi = partial remainder,     acc_lo = dividend out / quotient in.
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] opnd;        // multiplicand or divisor magnitude
  logic             op_div;      // current operation is a divide
  logic             neg_q;       // product / quotient must be negated
  logic             neg_r;       // remainder must be negated (sign of a)

  // Request decode and operand magnitudes
  logic             is_mul, is_div, is_signed, b_zero, sa, sb;
  logic             idle_req, run_go;
  logic [WIDTH-1:0] abs_a, abs_b;

  // Per-iteration and fixup datapath values
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Decode the incoming request and compute operand magnitudes
  always_comb begin
    is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    b_zero    = (b == '0);
    sa        = is_signed & a[WIDTH-1];
    sb        = is_signed & b[WIDTH-1];
    abs_a     = sa ? (~a + ONE_W) : a;
    abs_b     = sb ? (~b + ONE_W) : b;
    idle_req  = (state == S_IDLE) && start && !flush;
    run_go    = idle_req && (is_mul || (is_div && !b_zero));
  end

  // One shift-add / restoring-divide step plus the FIX-cycle sign correction
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    // Only used when div_ge, where the true difference fits in WIDTH bits.
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    prod_fix  = neg_q ? (~{acc_hi, acc_lo} + ONE_2W) : {acc_hi, acc_lo};
    quot_fix  = neg_q ? (~acc_lo + ONE_W) : acc_lo;
    rem_fix   = neg_r ? (~acc_hi + ONE_W) : acc_hi;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (run_go) state_n = S_RUN;
      S_RUN:   if (cnt == LAST) state_n = S_FIX;
      S_FIX:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  assign busy = (state != S_IDLE);

  // Datapath: operand latch, iterations, HI/LO writes and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      op_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!flush) begin
        case (state)
          S_IDLE: begin
            if (idle_req) begin
              if (op == OP_MTHI) begin
                hi <= a;
              end else if (op == OP_MTLO) begin
                lo <= a;
              end else if (is_div && b_zero) begin
                lo          <= '1;
                hi          <= a;
                div_by_zero <= 1'b1;
                done        <= 1'b1;
              end else if (run_go) begin
                cnt    <= '0;
                acc_hi <= '0;
                acc_lo <= is_div ? abs_a : abs_b;
                opnd   <= is_div ? abs_b : abs_a;
                op_div <= is_div;
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                if (!b_zero) div_by_zero <= 1'b0;
              end
            end
          end
          S_RUN: begin
            cnt <= cnt + CNT_W'(1);
            if (op_div) begin
              acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
          end
          S_FIX: begin
            if (op_div) begin
              lo <= quot_fix;
              hi <= rem_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
            done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside the ALU. Takes the same rs/rt operand buses.
- Owns the architectural HI/LO registers.
- Serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Its busy flag stalls the pipeline on MFHI/MFLO or a second mul/div. hi/lo feed the EX result mux.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source)
- b  input  WIDTH  rt operand (divisor / multiplier)
- flush  input  1  abort in-flight operation
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO updated by mul/div
- div_by_zero  output  1  sticky until next accepted start; set by DIV/DIVU with b=0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, async): state IDLE, counter 0, internal accumulators 0. Outputs: hi=0, lo=0, busy=0, done=0, div_by_zero=0.
- States: IDLE, RUN, FIX.
- IDLE, start=1, op=MTHI/MTLO: hi (resp. lo) <= a at that edge. busy stays 0; done stays 0.
- IDLE, start=1, op mul/div, b!=0 or multiply:
  - Latch |a| and |b| for signed ops, raw values for unsigned. Latch result sign(s) and counter=0.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, start=1, op DIV/DIVU with b=0:
  - lo <= all-ones, hi <= a, div_by_zero <= 1, done=1 for one cycle.
  - busy never asserts; remains IDLE.
- RUN: one iteration per cycle for exactly WIDTH cycles.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring; shift remainder left, trial subtract, set quotient bit on non-negative.
  - After the WIDTH-th iteration go to FIX.
- FIX (one cycle), mul: product negated if sign(a) xor sign(b) for MULT. {hi,lo} <= product at exit edge.
- FIX (one cycle), div: quotient negated if sign(a) xor sign(b); remainder takes the sign of a. lo <= quotient, hi <= remainder.
- FIX exit: done=1 for the following cycle, busy=0, state IDLE.
- Latency: start edge E0 → hi/lo valid and done=1 after edge E(WIDTH+1) (33 for WIDTH=32). busy high for exactly WIDTH+1 cycles.
- start while busy=1: ignored, not queued; a/b/op changes while busy have no effect.
- flush=1: return to IDLE next edge from any state. hi/lo unchanged, done not pulsed, busy=0 next cycle. flush has priority over a same-cycle start and over FIX completion.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no trap.
- div_by_zero cleared by any accepted mul/div start with b!=0; unaffected by MTHI/MTLO.
- Async reset mid-operation: immediate return to reset values; no partial HI/LO write.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; done one cycle; busy high exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 → lo=14, hi=2.
- DIV a=5, b=0 → next cycle lo=0xFFFFFFFF, hi=5, div_by_zero=1, done pulse, busy stays 0. Then MULTU 2×3 → div_by_zero=0, lo=6.
- MULTU 0x10000×0x10000 started; start=1 again at cycle 5 with different operands → ignored, result hi=1, lo=0. Repeat with flush at cycle 10 → hi/lo keep prior values, no done.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles → hi/lo updated at each edge, busy=0. Assert rst_n=0 mid-RUN → all outputs 0 immediately.
